// File: rtl/ad9739_pkg.sv
// Shared types and constants for the AD9739 waveform replay buffer.
package ad9739_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam logic [15:0] MIDSCALE = 16'h8000;
    localparam int          LANES    = 16;
    localparam int          SAMPLE_W = 16;
    localparam int          WORD_W   = LANES * SAMPLE_W;

    // Two's complement to offset binary is a single MSB flip.
    function automatic logic [SAMPLE_W-1:0] to_offset(input logic [SAMPLE_W-1:0] s, input logic twos);
        return twos ? {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]} : s;
    endfunction

endpackage

// File: rtl/ad9739_wave_ram.sv
// Simple dual-port word RAM: one write port, registered read port, no reset so it maps to block RAM.
module ad9739_wave_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 256
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ad9739_wave_buf.sv
// Waveform replay buffer: AXI-Stream load into RAM, gap-free 16-sample replay to the AD9739 serdes.
// Optional pass counter output play_cnt is enabled by defining AD9739_WAVE_BUF_PLAY_CNT_EN.
module ad9739_wave_buf
    import ad9739_pkg::*;
#(
    parameter  int IN_NUMS   = 4,
    parameter  int DEPTH     = 1024,
    parameter  int TWOS_COMP = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                      dac_clk,
    input  logic                      dac_rstn,
    input  logic                      load_start,
    input  logic                      play_en,
    input  logic [16*IN_NUMS-1:0]     s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic                      s_tlast,
    output logic [255:0]              dac_m_tdata,
    output logic                      dac_m_tvalid,
    output logic [ADDR_W:0]           wave_len,
    output logic                      load_err,
`ifdef AD9739_WAVE_BUF_PLAY_CNT_EN
    output logic [31:0]               play_cnt,
`endif
    output logic [1:0]                state
);

    state_t              r_state;
    logic [3:0]          r_lane;
    logic [ADDR_W:0]     r_wr_cnt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W:0]     r_wave_len;
    logic [WORD_W-1:0]   r_asm;
    logic [WORD_W-1:0]   r_dout;
    logic                r_rd_vld;
    logic                r_tvalid;
    logic                r_err;

    logic [WORD_W-1:0]   w_asm_nxt;
    logic [WORD_W-1:0]   w_rdata;
    logic [4:0]          w_lane_end;
    logic                w_beat;
    logic                w_full;
    logic                w_word_done;
    logic                w_we;
    logic                w_rd_wrap;

    // A restart in LOAD takes precedence over a beat presented on the same edge.
    assign w_beat      = (r_state == LOAD) && s_tvalid && !load_start;
    assign w_full      = (r_wr_cnt == (ADDR_W+1)'(DEPTH));
    assign w_lane_end  = {1'b0, r_lane} + 5'(IN_NUMS);
    assign w_word_done = (w_lane_end == 5'(LANES)) || s_tlast;
    assign w_we        = w_beat && !w_full && w_word_done;
    assign w_rd_wrap   = ({1'b0, r_rd_addr} == (r_wave_len - (ADDR_W+1)'(1)));

    always_comb begin
        w_asm_nxt = r_asm;
        for (int k = 0; k < IN_NUMS; k++) begin
            w_asm_nxt[(int'(r_lane) + k)*SAMPLE_W +: SAMPLE_W] =
                to_offset(s_tdata[k*SAMPLE_W +: SAMPLE_W], TWOS_COMP != 0);
        end
    end

    ad9739_wave_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .i_clk   (dac_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_cnt[ADDR_W-1:0]),
        .i_wdata (w_asm_nxt),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_state    <= IDLE;
            r_lane     <= '0;
            r_wr_cnt   <= '0;
            r_rd_addr  <= '0;
            r_wave_len <= '0;
            r_asm      <= {LANES{MIDSCALE}};
            r_dout     <= {LANES{MIDSCALE}};
            r_rd_vld   <= 1'b0;
            r_tvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_vld <= (r_state == PLAY);
            r_tvalid <= r_rd_vld;
            r_dout   <= r_rd_vld ? w_rdata : {LANES{MIDSCALE}};
            case (r_state)
                IDLE, LOAD: begin
                    if (load_start) begin
                        r_state  <= LOAD;
                        r_lane   <= '0;
                        r_wr_cnt <= '0;
                        r_err    <= 1'b0;
                        r_asm    <= {LANES{MIDSCALE}};
                    end else if (r_state == IDLE) begin
                        if (play_en && r_wave_len != '0) begin
                            r_state   <= PLAY;
                            r_rd_addr <= '0;
                        end
                    end else if (w_beat) begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else if (w_word_done) begin
                            // Refill with midscale so a short final word arrives pre-padded.
                            r_asm    <= {LANES{MIDSCALE}};
                            r_lane   <= '0;
                            r_wr_cnt <= r_wr_cnt + (ADDR_W+1)'(1);
                        end else begin
                            r_asm  <= w_asm_nxt;
                            r_lane <= w_lane_end[3:0];
                        end
                        if (s_tlast) begin
                            r_wave_len <= w_full ? r_wr_cnt : r_wr_cnt + (ADDR_W+1)'(1);
                            r_state    <= IDLE;
                        end
                    end
                end
                PLAY: begin
                    r_rd_addr <= w_rd_wrap ? '0 : r_rd_addr + ADDR_W'(1);
                    if (!play_en) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AD9739_WAVE_BUF_PLAY_CNT_EN
    logic [31:0] r_play_cnt;

    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            r_play_cnt <= '0;
        end else if (load_start && r_state != PLAY) begin
            r_play_cnt <= '0;
        end else if (r_state == PLAY && w_rd_wrap && r_play_cnt != 32'hFFFF_FFFF) begin
            r_play_cnt <= r_play_cnt + 32'd1;
        end
    end

    assign play_cnt = r_play_cnt;
`endif

    assign s_tready     = (r_state == LOAD);
    assign dac_m_tdata  = r_dout;
    assign dac_m_tvalid = r_tvalid;
    assign wave_len     = r_wave_len;
    assign load_err     = r_err;
    assign state        = r_state;

endmodule

// File: tb/tb_ad9739_wave_buf.sv
// Directed bench for ad9739_wave_buf with a scoreboard of expected replay words (DEPTH=2 to reach overflow).
module tb_ad9739_wave_buf;

    localparam int IN_NUMS = 4;
    localparam int DEPTH   = 2;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam logic [255:0] MID_WORD = {16{16'h8000}};

    logic                  dac_clk = 1'b0;
    logic                  dac_rstn;
    logic                  load_start;
    logic                  play_en;
    logic [16*IN_NUMS-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tlast;
    logic [255:0]          dac_m_tdata;
    logic                  dac_m_tvalid;
    logic [ADDR_W:0]       wave_len;
    logic                  load_err;
    logic [1:0]            state;
`ifdef AD9739_WAVE_BUF_PLAY_CNT_EN
    logic [31:0]           play_cnt;
`endif

    ad9739_wave_buf #(
        .IN_NUMS   (IN_NUMS),
        .DEPTH     (DEPTH),
        .TWOS_COMP (1)
    ) dut (
        .dac_clk      (dac_clk),
        .dac_rstn     (dac_rstn),
        .load_start   (load_start),
        .play_en      (play_en),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .dac_m_tdata  (dac_m_tdata),
        .dac_m_tvalid (dac_m_tvalid),
        .wave_len     (wave_len),
        .load_err     (load_err),
`ifdef AD9739_WAVE_BUF_PLAY_CNT_EN
        .play_cnt     (play_cnt),
`endif
        .state        (state)
    );

    always #5 dac_clk = ~dac_clk;

    int           checks = 0;
    int           errors = 0;
    logic [255:0] sb [$];
    logic [15:0]  samp [64];
    logic [255:0] exp_mem [DEPTH];
    int           nsamp;
    int           exp_len;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then score whatever the DUT presents.
    task automatic tick();
        logic [255:0] e;
        @(posedge dac_clk);
        #1;
        if (dac_m_tvalid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra observed=valid_word expected=no_word_pending");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_word", dac_m_tdata, e);
            end
        end else begin
            chk("idle_midscale", dac_m_tdata, MID_WORD);
        end
    endtask

    function automatic logic [15:0] gen(input int kind, input int i);
        case (kind)
            0:       return 16'(i);
            1:       return 16'(32'hFFF0 + i);
            2:       return 16'(32'h1000 + 3*i);
            default: return 16'(32'h7FFF - i);
        endcase
    endfunction

    task automatic load_rec(input int nb, input int kind);
        int idx;
        nsamp = nb * IN_NUMS;
        for (int i = 0; i < nsamp; i++) samp[i] = gen(kind, i);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_state", 256'(state), 256'(1));
        chk("load_ready", 256'(s_tready), 256'(1));
        chk("load_err_clr", 256'(load_err), 256'(0));
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < IN_NUMS; k++) s_tdata[k*16 +: 16] = samp[b*IN_NUMS + k];
            s_tvalid = 1'b1;
            s_tlast  = (b == nb - 1);
            chk("beat_ready", 256'(s_tready), 256'(1));
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        exp_len = (nsamp + 15) / 16;
        if (exp_len > DEPTH) exp_len = DEPTH;
        chk("load_done_state", 256'(state), 256'(0));
        chk("wave_len", 256'(wave_len), 256'(exp_len));
        chk("load_err", 256'(load_err), 256'(nsamp > DEPTH*16));
        for (int w = 0; w < DEPTH; w++) begin
            for (int l = 0; l < 16; l++) begin
                idx = w*16 + l;
                exp_mem[w][l*16 +: 16] = (idx < nsamp) ? (samp[idx] ^ 16'h8000) : 16'h8000;
            end
        end
    endtask

    // Replay for n PLAY cycles; optionally pulse load_start on cycle ls_at, then drain.
    task automatic play(input int n, input int ls_at);
        for (int j = 0; j < n; j++) sb.push_back(exp_mem[j % exp_len]);
        play_en = 1'b1;
        for (int j = 0; j < n; j++) begin
            load_start = (j == ls_at);
            tick();
            chk("play_state", 256'(state), 256'(2));
            if (j < 2) chk("play_latency", 256'(dac_m_tvalid), 256'(0));
        end
        load_start = 1'b0;
        play_en    = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        chk("play_drained", 256'(sb.size()), 256'(0));
        chk("play_stopped", 256'(dac_m_tvalid), 256'(0));
        chk("stop_state", 256'(state), 256'(0));
    endtask

    initial begin
        dac_rstn   = 1'b0;
        load_start = 1'b0;
        play_en    = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;

        tick();
        tick();
        chk("rst_state", 256'(state), 256'(0));
        chk("rst_ready", 256'(s_tready), 256'(0));
        chk("rst_valid", 256'(dac_m_tvalid), 256'(0));
        chk("rst_wave_len", 256'(wave_len), 256'(0));
        chk("rst_load_err", 256'(load_err), 256'(0));
        dac_rstn = 1'b1;
        tick();

        // Ramp 0..31, two full words.
        load_rec(8, 0);
        chk("ramp_lane0", 256'(exp_mem[0][15:0]), 256'(16'h8000));
        play(6, -1);
`ifdef AD9739_WAVE_BUF_PLAY_CNT_EN
        chk("play_cnt", 256'(play_cnt), 256'(3));
`endif

        // load_start beats play_en in IDLE.
        load_start = 1'b1;
        play_en    = 1'b1;
        tick();
        load_start = 1'b0;
        play_en    = 1'b0;
        chk("prio_state", 256'(state), 256'(1));
        chk("prio_valid", 256'(dac_m_tvalid), 256'(0));

        // Partial record (restarts the load already in progress); load_start during PLAY ignored.
        load_rec(5, 1);
        play(6, 2);

        // Overflow: 13 beats into a 2-word RAM.
        load_rec(13, 2);
        play(4, -1);
        chk("err_sticky", 256'(load_err), 256'(1));

        // One-word record repeats every cycle.
        load_rec(1, 3);
        play(3, -1);

        // Asynchronous reset in the middle of replay.
        for (int j = 0; j < 8; j++) sb.push_back(exp_mem[0]);
        play_en = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        chk("pre_rst_valid", 256'(dac_m_tvalid), 256'(1));
        #1;
        dac_rstn = 1'b0;
        #1;
        chk("arst_valid", 256'(dac_m_tvalid), 256'(0));
        chk("arst_data", dac_m_tdata, MID_WORD);
        chk("arst_wave_len", 256'(wave_len), 256'(0));
        chk("arst_state", 256'(state), 256'(0));
        chk("arst_ready", 256'(s_tready), 256'(0));
        sb.delete();
        @(negedge dac_clk);
        dac_rstn = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        chk("no_replay_after_rst", 256'(state), 256'(0));
        play_en = 1'b0;
        tick();
        chk("sb_final", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
